// File: rtl/sfp_port_mgr_if.sv
// rtl/sfp_port_mgr_if.sv - SFP cage pins and MAC-side link signals for sfp_port_mgr
//
// Bundles the per-port vectors exchanged between the SFP cages, the per-port
// eth_top instances and the port manager. Bit i of every vector belongs to
// port i; fault_cnt packs port i at [8i+7:8i].
//   sfp_rx_los      raw LOS pins (asynchronous)
//   sfp_tx_fault    raw TX_FAULT pins (asynchronous)
//   port_enable     static per-port enable
//   mac_link_up     PCS block-lock / link status
//   sfp_tx_disable  1 = laser off
//   mac_rst         active-high reset to eth_top
//   port_up         1 = port in UP
//   led             status LED
//   fault_cnt       saturating fault-entry counters
// The slave modport is the port manager; the master modport is its environment.

interface sfp_port_mgr_if #(
    parameter int NUM_PORTS = 4
) ();
    logic [NUM_PORTS-1:0]   sfp_rx_los;
    logic [NUM_PORTS-1:0]   sfp_tx_fault;
    logic [NUM_PORTS-1:0]   port_enable;
    logic [NUM_PORTS-1:0]   mac_link_up;
    logic [NUM_PORTS-1:0]   sfp_tx_disable;
    logic [NUM_PORTS-1:0]   mac_rst;
    logic [NUM_PORTS-1:0]   port_up;
    logic [NUM_PORTS-1:0]   led;
    logic [8*NUM_PORTS-1:0] fault_cnt;

    modport master (
        output sfp_rx_los, sfp_tx_fault, port_enable, mac_link_up,
        input  sfp_tx_disable, mac_rst, port_up, led, fault_cnt
    );

    modport slave (
        input  sfp_rx_los, sfp_tx_fault, port_enable, mac_link_up,
        output sfp_tx_disable, mac_rst, port_up, led, fault_cnt
    );
endinterface

// File: rtl/sfp_port_mgr.sv
// rtl/sfp_port_mgr.sv - per-port SFP link manager (debounce, TX_DISABLE/MAC reset sequencing, fault counting, LED)
//
// Ports:
//   clk200   system clock (200 MHz)
//   sys_rst  synchronous active-high reset
//   bus      sfp_port_mgr_if.slave: SFP pins, enables, MAC link status in;
//            tx_disable, mac_rst, port_up, led, fault_cnt out
// Parameters:
//   NUM_PORTS        number of SFP channels (1..8)
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced pin changes
//   STABLE_CYCLES    settle window after MAC reset release
//   RETRY_CYCLES     FAULT hold-off before automatic retry
//   BLINK_BIT        blink counter bit for slow blink (must be >= 2)
// Build option:
//   SFP_AUTO_RETRY_EN  when defined, FAULT retries after RETRY_CYCLES once
//                      TX_FAULT has cleared; otherwise FAULT is sticky until
//                      port_enable drops or sys_rst.

module sfp_port_mgr #(
    parameter int NUM_PORTS       = 4,
    parameter int DEBOUNCE_CYCLES = 2000,
    parameter int STABLE_CYCLES   = 200000,
    parameter int RETRY_CYCLES    = 2000000,
    parameter int BLINK_BIT       = 24
) (
    input  logic           clk200,
    input  logic           sys_rst,
    sfp_port_mgr_if.slave  bus
);

    localparam int TMR_MAX = (STABLE_CYCLES > RETRY_CYCLES) ? STABLE_CYCLES : RETRY_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int DCW     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  STABLE_LOAD = TW'(STABLE_CYCLES - 1);
`ifdef SFP_AUTO_RETRY_EN
    localparam logic [TW-1:0]  RETRY_LOAD  = TW'(RETRY_CYCLES - 1);
`endif

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_WAIT_SIG = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_UP       = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    // Shared free-running blink counter; only bits up to BLINK_BIT matter.
    logic [BLINK_BIT:0] blink_cnt;

    // Two-flop synchronisers for the asynchronous cage pins.
    logic [NUM_PORTS-1:0] los_s1, los_s2;
    logic [NUM_PORTS-1:0] flt_s1, flt_s2;

    // Debounced pin values and their stability counters.
    logic [NUM_PORTS-1:0] deb_los, deb_flt;
    logic [DCW-1:0]       los_cnt [NUM_PORTS];
    logic [DCW-1:0]       flt_cnt [NUM_PORTS];

    // Per-port FSM, shared SETTLE/FAULT timer and fault counter.
    logic [2:0]           state   [NUM_PORTS];
    logic [TW-1:0]        timer   [NUM_PORTS];
    logic [7:0]           fcnt    [NUM_PORTS];

    // Output vectors before they are handed to the interface.
    logic [NUM_PORTS-1:0]   tx_disable_v;
    logic [NUM_PORTS-1:0]   mac_rst_v;
    logic [NUM_PORTS-1:0]   port_up_v;
    logic [NUM_PORTS-1:0]   led_v;
    logic [8*NUM_PORTS-1:0] fault_cnt_v;

    always_ff @(posedge clk200) begin
        if (sys_rst) begin
            blink_cnt <= '0;
            los_s1    <= '1;
            los_s2    <= '1;
            flt_s1    <= '0;
            flt_s2    <= '0;
            deb_los   <= '1;
            deb_flt   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                los_cnt[i] <= '0;
                flt_cnt[i] <= '0;
                state[i]   <= ST_OFF;
                timer[i]   <= '0;
                fcnt[i]    <= '0;
            end
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            los_s1    <= bus.sfp_rx_los;
            los_s2    <= los_s1;
            flt_s1    <= bus.sfp_tx_fault;
            flt_s2    <= flt_s1;

            for (int i = 0; i < NUM_PORTS; i++) begin
                // Debounce: count cycles the synchronised value disagrees with
                // the debounced one; returning to agreement restarts the count.
                if (los_s2[i] == deb_los[i]) begin
                    los_cnt[i] <= '0;
                end else if (los_cnt[i] == DEB_LAST) begin
                    deb_los[i] <= los_s2[i];
                    los_cnt[i] <= '0;
                end else begin
                    los_cnt[i] <= los_cnt[i] + 1'b1;
                end

                if (flt_s2[i] == deb_flt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == DEB_LAST) begin
                    deb_flt[i] <= flt_s2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end

                // FSM acts on the registered debounced values, so a pin edge
                // reaches the state one cycle after the debouncer flips.
                if (!bus.port_enable[i]) begin
                    // Enable drop overrides any simultaneous event, and no
                    // fault is counted on this edge.
                    state[i] <= ST_OFF;
                    timer[i] <= '0;
                end else begin
                    case (state[i])
                        ST_OFF: begin
                            state[i] <= ST_WAIT_SIG;
                        end
                        ST_WAIT_SIG: begin
                            if (deb_flt[i]) begin
                                state[i] <= ST_FAULT;
                                if (fcnt[i] != 8'hFF) fcnt[i] <= fcnt[i] + 1'b1;
`ifdef SFP_AUTO_RETRY_EN
                                timer[i] <= RETRY_LOAD;
`endif
                            end else if (!deb_los[i]) begin
                                state[i] <= ST_SETTLE;
                                timer[i] <= STABLE_LOAD;
                            end
                        end
                        ST_SETTLE: begin
                            if (deb_flt[i]) begin
                                state[i] <= ST_FAULT;
                                if (fcnt[i] != 8'hFF) fcnt[i] <= fcnt[i] + 1'b1;
`ifdef SFP_AUTO_RETRY_EN
                                timer[i] <= RETRY_LOAD;
`endif
                            end else if (deb_los[i]) begin
                                state[i] <= ST_WAIT_SIG;
                            end else if (timer[i] == '0) begin
                                // No link after the settle window: go back and
                                // re-reset the MAC for another attempt.
                                state[i] <= bus.mac_link_up[i] ? ST_UP : ST_WAIT_SIG;
                            end else begin
                                timer[i] <= timer[i] - 1'b1;
                            end
                        end
                        ST_UP: begin
                            if (deb_flt[i]) begin
                                state[i] <= ST_FAULT;
                                if (fcnt[i] != 8'hFF) fcnt[i] <= fcnt[i] + 1'b1;
`ifdef SFP_AUTO_RETRY_EN
                                timer[i] <= RETRY_LOAD;
`endif
                            end else if (deb_los[i] || !bus.mac_link_up[i]) begin
                                state[i] <= ST_WAIT_SIG;
                            end
                        end
                        ST_FAULT: begin
`ifdef SFP_AUTO_RETRY_EN
                            // A fault still present at expiry re-arms the
                            // hold-off without counting a new entry.
                            if (timer[i] == '0) begin
                                if (deb_flt[i]) begin
                                    timer[i] <= RETRY_LOAD;
                                end else begin
                                    state[i] <= ST_WAIT_SIG;
                                end
                            end else begin
                                timer[i] <= timer[i] - 1'b1;
                            end
`else
                            // Sticky: only the enable drop above leaves FAULT.
                            state[i] <= ST_FAULT;
`endif
                        end
                        default: begin
                            state[i] <= ST_OFF;
                            timer[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Moore output decode from registered state and blink counter only.
    always_comb begin
        tx_disable_v = '1;
        mac_rst_v    = '1;
        port_up_v    = '0;
        led_v        = '0;
        fault_cnt_v  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            fault_cnt_v[8*i +: 8] = fcnt[i];
            case (state[i])
                ST_WAIT_SIG: begin
                    tx_disable_v[i] = 1'b0;
                    led_v[i]        = blink_cnt[BLINK_BIT];
                end
                ST_SETTLE: begin
                    tx_disable_v[i] = 1'b0;
                    mac_rst_v[i]    = 1'b0;
                    led_v[i]        = blink_cnt[BLINK_BIT];
                end
                ST_UP: begin
                    tx_disable_v[i] = 1'b0;
                    mac_rst_v[i]    = 1'b0;
                    port_up_v[i]    = 1'b1;
                    led_v[i]        = 1'b1;
                end
                ST_FAULT: begin
                    led_v[i]        = blink_cnt[BLINK_BIT-2];
                end
                default: begin
                    led_v[i]        = 1'b0;
                end
            endcase
        end
    end

    assign bus.sfp_tx_disable = tx_disable_v;
    assign bus.mac_rst        = mac_rst_v;
    assign bus.port_up        = port_up_v;
    assign bus.led            = led_v;
    assign bus.fault_cnt      = fault_cnt_v;

endmodule

// File: tb/tb_sfp_port_mgr.sv
// tb/tb_sfp_port_mgr.sv - self-checking bench for sfp_port_mgr with a behavioural reference model

module tb_sfp_port_mgr;

    localparam int NP  = 2;
    localparam int DEB = 4;
    localparam int STB = 16;
    localparam int RTY = 32;
    localparam int BB  = 3;

    // Model states (independent numbering from the design)
    localparam int M_OFF = 10, M_WAIT = 11, M_SETTLE = 12, M_UP = 13, M_FAULT = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sfp_port_mgr_if #(.NUM_PORTS(NP)) bus ();

    sfp_port_mgr #(
        .NUM_PORTS      (NP),
        .DEBOUNCE_CYCLES(DEB),
        .STABLE_CYCLES  (STB),
        .RETRY_CYCLES   (RTY),
        .BLINK_BIT      (BB)
    ) dut (
        .clk200 (clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_st    [NP];
    int m_dwell [NP];   // cycles spent in SETTLE / current FAULT hold-off
    int m_fcnt  [NP];
    int m_cyc;
    bit m_l1 [NP], m_l2 [NP], m_f1 [NP], m_f2 [NP];
    bit m_dl [NP], m_df [NP];
    bit m_lrv [NP], m_frv [NP];
    int m_lrun [NP], m_frun [NP];

    task automatic enter_fault(input int p);
        m_st[p]    = M_FAULT;
        m_dwell[p] = 0;
        if (m_fcnt[p] < 255) m_fcnt[p]++;
    endtask

    task automatic model_step();
        if (rst) begin
            m_cyc = 0;
            for (int p = 0; p < NP; p++) begin
                m_st[p] = M_OFF; m_dwell[p] = 0; m_fcnt[p] = 0;
                m_l1[p] = 1; m_l2[p] = 1; m_f1[p] = 0; m_f2[p] = 0;
                m_dl[p] = 1; m_df[p] = 0;
                m_lrv[p] = 1; m_lrun[p] = 0; m_frv[p] = 0; m_frun[p] = 0;
            end
            return;
        end
        m_cyc++;
        for (int p = 0; p < NP; p++) begin
            bit en, lk, dl, df;
            en = bus.port_enable[p];
            lk = bus.mac_link_up[p];
            dl = m_dl[p];
            df = m_df[p];
            if (!en) begin
                m_st[p] = M_OFF;
            end else begin
                case (m_st[p])
                    M_OFF:  m_st[p] = M_WAIT;
                    M_WAIT: begin
                        if (df) enter_fault(p);
                        else if (!dl) begin m_st[p] = M_SETTLE; m_dwell[p] = 0; end
                    end
                    M_SETTLE: begin
                        if (df) enter_fault(p);
                        else if (dl) m_st[p] = M_WAIT;
                        else begin
                            m_dwell[p]++;
                            if (m_dwell[p] == STB) m_st[p] = lk ? M_UP : M_WAIT;
                        end
                    end
                    M_UP: begin
                        if (df) enter_fault(p);
                        else if (dl || !lk) m_st[p] = M_WAIT;
                    end
                    default: begin
`ifdef SFP_AUTO_RETRY_EN
                        m_dwell[p]++;
                        if (m_dwell[p] == RTY) begin
                            if (df) m_dwell[p] = 0;
                            else    m_st[p] = M_WAIT;
                        end
`endif
                    end
                endcase
            end
            // debounce: a run of DEB identical synchronised samples sets the value
            if (m_l2[p] == m_lrv[p]) begin if (m_lrun[p] < DEB) m_lrun[p]++; end
            else begin m_lrv[p] = m_l2[p]; m_lrun[p] = 1; end
            if (m_lrun[p] >= DEB) m_dl[p] = m_lrv[p];
            if (m_f2[p] == m_frv[p]) begin if (m_frun[p] < DEB) m_frun[p]++; end
            else begin m_frv[p] = m_f2[p]; m_frun[p] = 1; end
            if (m_frun[p] >= DEB) m_df[p] = m_frv[p];
            m_l2[p] = m_l1[p]; m_l1[p] = bus.sfp_rx_los[p];
            m_f2[p] = m_f1[p]; m_f1[p] = bus.sfp_tx_fault[p];
        end
    endtask

    task automatic tick();
        logic [NP-1:0]   e_txd, e_rst, e_up, e_led;
        logic [8*NP-1:0] e_fc;
        @(posedge clk);
        #1;
        model_step();
        for (int p = 0; p < NP; p++) begin
            e_txd[p] = (m_st[p] == M_OFF) || (m_st[p] == M_FAULT);
            e_rst[p] = (m_st[p] != M_SETTLE) && (m_st[p] != M_UP);
            e_up[p]  = (m_st[p] == M_UP);
            case (m_st[p])
                M_WAIT, M_SETTLE: e_led[p] = m_cyc[BB];
                M_UP:             e_led[p] = 1'b1;
                M_FAULT:          e_led[p] = m_cyc[BB-2];
                default:          e_led[p] = 1'b0;
            endcase
            e_fc[8*p +: 8] = 8'(m_fcnt[p]);
        end
        check("tx_disable", 32'(bus.sfp_tx_disable), 32'(e_txd));
        check("mac_rst",    32'(bus.mac_rst),        32'(e_rst));
        check("port_up",    32'(bus.port_up),        32'(e_up));
        check("led",        32'(bus.led),            32'(e_led));
        check("fault_cnt",  32'(bus.fault_cnt),      32'(e_fc));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_up(input int p, input int limit);
        int k;
        k = 0;
        while (!bus.port_up[p] && k < limit) begin tick(); k++; end
        check("reach_up", 32'(bus.port_up[p]), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.sfp_rx_los   = '1;
        bus.sfp_tx_fault = '0;
        bus.port_enable  = '0;
        bus.mac_link_up  = '0;
        ticks(3);
        check("rst_txd",  32'(bus.sfp_tx_disable), 32'h3);
        check("rst_mrst", 32'(bus.mac_rst),        32'h3);
        check("rst_up",   32'(bus.port_up),        32'h0);
        check("rst_led",  32'(bus.led),            32'h0);
        check("rst_fcnt", 32'(bus.fault_cnt),      32'h0);

        // bring-up latency of port 0, port 1 left alone
        rst = 1'b0;
        bus.port_enable = 2'b01;
        bus.sfp_rx_los  = 2'b10;
        bus.mac_link_up = 2'b01;
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 1) begin
                check("en_txd0", 32'(bus.sfp_tx_disable[0]), 32'd0);
                check("en_mrst0", 32'(bus.mac_rst[0]), 32'd1);
            end
            if (k == 6)  check("mrst_before", 32'(bus.mac_rst[0]), 32'd1);
            if (k == 7)  check("mrst_fall",   32'(bus.mac_rst[0]), 32'd0);
            if (k == 22) check("up_early",    32'(bus.port_up[0]), 32'd0);
        end
        check("up_on_time", 32'(bus.port_up[0]), 32'd1);
        check("up_led",     32'(bus.led[0]), 32'd1);
        check("p1_txd",     32'(bus.sfp_tx_disable[1]), 32'd1);

        // 3-cycle LOS glitch is filtered, longer one drops the link
        bus.sfp_rx_los[0] = 1'b1; ticks(3);
        bus.sfp_rx_los[0] = 1'b0; ticks(10);
        check("glitch_up", 32'(bus.port_up[0]), 32'd1);
        bus.sfp_rx_los[0] = 1'b1; ticks(8);
        check("los_up",   32'(bus.port_up[0]), 32'd0);
        check("los_mrst", 32'(bus.mac_rst[0]), 32'd1);
        ticks(20);

        // settle expiry without link loops through WAIT_SIG
        bus.sfp_rx_los[0] = 1'b0;
        bus.mac_link_up[0] = 1'b0;
        ticks(60);
        bus.mac_link_up[0] = 1'b1;
        wait_up(0, 100);

        // TX fault in UP
        bus.sfp_tx_fault[0] = 1'b1;
        ticks(7);
        check("flt_txd",  32'(bus.sfp_tx_disable[0]), 32'd1);
        check("flt_cnt1", 32'(bus.fault_cnt[7:0]), 32'd1);
        ticks(40);
        check("flt_cnt_hold", 32'(bus.fault_cnt[7:0]), 32'd1);
        bus.sfp_tx_fault[0] = 1'b0;
        ticks(60);
        bus.port_enable[0] = 1'b0; ticks(2);
        check("off_txd", 32'(bus.sfp_tx_disable[0]), 32'd1);
        bus.port_enable[0] = 1'b1;
        wait_up(0, 100);

        // LOS and fault together: fault wins
        bus.sfp_rx_los[0] = 1'b1; bus.sfp_tx_fault[0] = 1'b1;
        ticks(8);
        check("both_txd", 32'(bus.sfp_tx_disable[0]), 32'd1);
        check("both_up",  32'(bus.port_up[0]), 32'd0);

        // saturation on port 1
        bus.sfp_tx_fault[1] = 1'b1;
        bus.port_enable[1]  = 1'b1;
        ticks(8);
        for (int n = 0; n < 300; n++) begin
            bus.port_enable[1] = 1'b0; tick();
            bus.port_enable[1] = 1'b1; ticks(3);
        end
        check("sat_cnt", 32'(bus.fault_cnt[15:8]), 32'hFF);

        // randomized segments
        for (int s = 0; s < 150; s++) begin
            for (int p = 0; p < NP; p++) begin
                bus.sfp_rx_los[p]   = ($urandom_range(3) == 0);
                bus.sfp_tx_fault[p] = ($urandom_range(7) == 0);
                bus.port_enable[p]  = ($urandom_range(7) != 0);
                bus.mac_link_up[p]  = ($urandom_range(3) != 0);
            end
            rst = ($urandom_range(39) == 0);
            if (rst) begin tick(); rst = 1'b0; end
            ticks($urandom_range(40, 1));
        end

        // sys_rst while UP
        bus.sfp_rx_los = '0; bus.sfp_tx_fault = '0; bus.mac_link_up = '1;
        bus.port_enable = '0; tick();
        bus.port_enable = '1;
        wait_up(0, 200);
        rst = 1'b1; tick();
        check("srst_txd",  32'(bus.sfp_tx_disable), 32'h3);
        check("srst_mrst", 32'(bus.mac_rst),        32'h3);
        check("srst_up",   32'(bus.port_up),        32'h0);
        check("srst_led",  32'(bus.led),            32'h0);
        check("srst_fcnt", 32'(bus.fault_cnt),      32'h0);
        rst = 1'b0;
        ticks(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
